// File: rtl/ddr2_init_sequencer_if.sv
// DDR2 command/address bus between the init sequencer and the controller
// command mux.
//   dram_cke                          clock enable
//   dram_cs_n/ras_n/cas_n/we_n        command strobes
//   dram_ba   [BANK_WIDTH-1:0]        bank address
//   dram_addr [ROW_WIDTH-1:0]         address / mode register value
// master: drives the bus (sequencer); slave: observes it (mux, bench).
interface ddr2_init_sequencer_if #(
    parameter int ROW_WIDTH  = 14,
    parameter int BANK_WIDTH = 3
);
    logic                  dram_cke;
    logic                  dram_cs_n;
    logic                  dram_ras_n;
    logic                  dram_cas_n;
    logic                  dram_we_n;
    logic [BANK_WIDTH-1:0] dram_ba;
    logic [ROW_WIDTH-1:0]  dram_addr;

    modport master (
        output dram_cke, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
        output dram_ba, dram_addr
    );

    modport slave (
        input dram_cke, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
        input dram_ba, dram_addr
    );
endinterface

// File: rtl/ddr2_init_sequencer.sv
// DDR2 power-up / initialisation sequencer. Runs on the divided DRAM clock,
// holds the bus in DESEL/NOP and walks the JEDEC init command list, then
// raises init_done (sticky until reset) and leaves the bus in NOP.
// Ports:
//   dram_clk_div    in   sequencer clock
//   dram_rst_div_n  in   asynchronous active-low reset
//   phy_rdy         in   PHY ready; only sampled while in PWRUP
//   dram            out  command/address bus (master modport)
//   init_done       out  sequence complete
//
// state    | meaning
// ---------+----------------------------------------------------------
// PWRUP    | CKE low, DESEL, count power-up delay, wait for phy_rdy
// CKE      | CKE high, NOP for tXPR
// PRE1     | PRECHARGE ALL, wait tRP
// EMR2     | MRS to EMR2 (all zero), wait tMRD
// EMR3     | MRS to EMR3 (all zero), wait tMRD
// EMR1     | MRS to EMR1 (DLL on, RTT 75R, AL), wait tMRD
// MRDLL    | MRS to MR with DLL reset, starts DLL lock timer
// PRE2     | PRECHARGE ALL, wait tRP
// REF1     | AUTO REFRESH, wait tRFC
// REF2     | AUTO REFRESH, wait tRFC
// MR       | MRS to MR without DLL reset, wait tMRD
// OCDDEF   | MRS to EMR1 with OCD default, wait tMRD
// OCDEX    | MRS to EMR1 with OCD exit, wait tMRD
// DLLWAIT  | NOP until DLL lock time has elapsed since MRDLL
// DONE     | init_done, NOP, terminal
module ddr2_init_sequencer #(
    parameter int ROW_WIDTH  = 14,
    parameter int BANK_WIDTH = 3,
    parameter int T_PWRUP    = 26600,
    parameter int T_XPR      = 54,
    parameter int T_RP       = 2,
    parameter int T_MRD      = 2,
    parameter int T_RFC      = 18,
    parameter int T_DLL      = 200,
    parameter int CAS_LAT    = 4,
    parameter int BURST_LEN  = 4,
    parameter int WR_REC     = 4,
    parameter int ADD_LAT    = 0
) (
    input  logic                         dram_clk_div,
    input  logic                         dram_rst_div_n,
    input  logic                         phy_rdy,
    ddr2_init_sequencer_if.master        dram,
    output logic                         init_done
);

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int PWRUP_E = at_least_one(T_PWRUP);
    localparam int XPR_E   = at_least_one(T_XPR);
    localparam int RP_E    = at_least_one(T_RP);
    localparam int MRD_E   = at_least_one(T_MRD);
    localparam int RFC_E   = at_least_one(T_RFC);
    localparam int DLL_E   = at_least_one(T_DLL);
    localparam int WMAX    = max2(max2(PWRUP_E, XPR_E), max2(max2(RP_E, MRD_E), RFC_E));
    localparam int WCNT_W  = $clog2(WMAX + 1);
    localparam int DLL_W   = $clog2(DLL_E + 1);

    // PWRUP counts up from the cleared reset value; every other state loads
    // its wait and counts down to zero. CKE loads one less because its own
    // entry cycle is already the first NOP of tXPR.
    localparam logic [WCNT_W-1:0] PWRUP_TC = WCNT_W'(PWRUP_E - 1);
    localparam logic [WCNT_W-1:0] XPR_LD   = WCNT_W'(XPR_E - 1);
    localparam logic [WCNT_W-1:0] RP_LD    = WCNT_W'(RP_E);
    localparam logic [WCNT_W-1:0] MRD_LD   = WCNT_W'(MRD_E);
    localparam logic [WCNT_W-1:0] RFC_LD   = WCNT_W'(RFC_E);
    localparam logic [DLL_W-1:0]  DLL_MAX  = DLL_W'(DLL_E);
    localparam logic [DLL_W-1:0]  DLL_TC   = DLL_W'(DLL_E - 1);

    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    localparam logic [2:0] BL_CODE = (BURST_LEN == 8) ? 3'b011 : 3'b010;
    localparam logic [2:0] CL_CODE = 3'(CAS_LAT);
    localparam logic [2:0] WR_CODE = 3'(WR_REC - 1);
    localparam logic [2:0] AL_CODE = 3'(ADD_LAT);

    localparam logic [ROW_WIDTH-1:0] MR_VAL   = ROW_WIDTH'({WR_CODE, 2'b00, CL_CODE, 1'b0, BL_CODE});
    localparam logic [ROW_WIDTH-1:0] EMR1_VAL = ROW_WIDTH'({6'b000000, AL_CODE, 3'b100});
    localparam logic [ROW_WIDTH-1:0] A8_DLL   = ROW_WIDTH'(12'h100);
    localparam logic [ROW_WIDTH-1:0] A10_ALL  = ROW_WIDTH'(12'h400);
    localparam logic [ROW_WIDTH-1:0] OCD_DEF  = ROW_WIDTH'(12'h380);

    typedef enum logic [3:0] {
        S_PWRUP, S_CKE, S_PRE1, S_EMR2, S_EMR3, S_EMR1, S_MRDLL, S_PRE2,
        S_REF1, S_REF2, S_MR, S_OCDDEF, S_OCDEX, S_DLLWAIT, S_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [WCNT_W-1:0]      wcnt, wcnt_nxt;
    logic [DLL_W-1:0]       dll_cnt;
    logic                   dll_run;
    logic                   dll_ok;
    logic                   wait_done;
    logic [3:0]             cmd_nxt;
    logic [BANK_WIDTH-1:0]  ba_nxt;
    logic [ROW_WIDTH-1:0]   addr_nxt;

    function automatic logic [WCNT_W-1:0] wait_of(input state_t s);
        case (s)
            S_CKE:                    return XPR_LD;
            S_PRE1, S_PRE2:           return RP_LD;
            S_REF1, S_REF2:           return RFC_LD;
            S_EMR2, S_EMR3, S_EMR1, S_MRDLL,
            S_MR, S_OCDDEF, S_OCDEX:  return MRD_LD;
            default:                  return '0;
        endcase
    endfunction

    // dll_cnt reads k in the k-th cycle after MRDLL, so a next-cycle count
    // of T_DLL is reached when the current count is T_DLL-1.
    assign dll_ok    = dll_run && (dll_cnt >= DLL_TC);
    assign wait_done = (wcnt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_PWRUP:   if (wcnt == PWRUP_TC && phy_rdy) state_nxt = S_CKE;
            S_CKE:     if (wait_done) state_nxt = S_PRE1;
            S_PRE1:    if (wait_done) state_nxt = S_EMR2;
            S_EMR2:    if (wait_done) state_nxt = S_EMR3;
            S_EMR3:    if (wait_done) state_nxt = S_EMR1;
            S_EMR1:    if (wait_done) state_nxt = S_MRDLL;
            S_MRDLL:   if (wait_done) state_nxt = S_PRE2;
            S_PRE2:    if (wait_done) state_nxt = S_REF1;
            S_REF1:    if (wait_done) state_nxt = S_REF2;
            S_REF2:    if (wait_done) state_nxt = S_MR;
            S_MR:      if (wait_done) state_nxt = S_OCDDEF;
            S_OCDDEF:  if (wait_done) state_nxt = S_OCDEX;
            S_OCDEX:   if (wait_done) state_nxt = dll_ok ? S_DONE : S_DLLWAIT;
            S_DLLWAIT: if (dll_ok) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_DONE;
            default:   state_nxt = S_PWRUP;
        endcase

        wcnt_nxt = wcnt;
        if (state_nxt != state) begin
            wcnt_nxt = wait_of(state_nxt);
        end else if (state == S_PWRUP) begin
            if (wcnt != PWRUP_TC) wcnt_nxt = wcnt + WCNT_W'(1);
        end else if (!wait_done) begin
            wcnt_nxt = wcnt - WCNT_W'(1);
        end

        // A command goes out only in the cycle its state is entered.
        cmd_nxt  = (state_nxt == S_PWRUP) ? CMD_DESEL : CMD_NOP;
        ba_nxt   = '0;
        addr_nxt = '0;
        if (state_nxt != state) begin
            case (state_nxt)
                S_PRE1, S_PRE2: begin
                    cmd_nxt  = CMD_PRE;
                    addr_nxt = A10_ALL;
                end
                S_EMR2: begin
                    cmd_nxt = CMD_MRS;
                    ba_nxt  = BANK_WIDTH'(2);
                end
                S_EMR3: begin
                    cmd_nxt = CMD_MRS;
                    ba_nxt  = BANK_WIDTH'(3);
                end
                S_EMR1, S_OCDEX: begin
                    cmd_nxt  = CMD_MRS;
                    ba_nxt   = BANK_WIDTH'(1);
                    addr_nxt = EMR1_VAL;
                end
                S_OCDDEF: begin
                    cmd_nxt  = CMD_MRS;
                    ba_nxt   = BANK_WIDTH'(1);
                    addr_nxt = EMR1_VAL | OCD_DEF;
                end
                S_MRDLL: begin
                    cmd_nxt  = CMD_MRS;
                    addr_nxt = MR_VAL | A8_DLL;
                end
                S_MR: begin
                    cmd_nxt  = CMD_MRS;
                    addr_nxt = MR_VAL;
                end
                S_REF1, S_REF2: cmd_nxt = CMD_REF;
                default: ;
            endcase
        end
    end

    always_ff @(posedge dram_clk_div or negedge dram_rst_div_n) begin
        if (!dram_rst_div_n) begin
            state          <= S_PWRUP;
            wcnt           <= '0;
            dll_cnt        <= '0;
            dll_run        <= 1'b0;
            dram.dram_cke  <= 1'b0;
            {dram.dram_cs_n, dram.dram_ras_n, dram.dram_cas_n, dram.dram_we_n} <= CMD_DESEL;
            dram.dram_ba   <= '0;
            dram.dram_addr <= '0;
            init_done      <= 1'b0;
        end else begin
            state          <= state_nxt;
            wcnt           <= wcnt_nxt;
            dram.dram_cke  <= (state_nxt != S_PWRUP);
            {dram.dram_cs_n, dram.dram_ras_n, dram.dram_cas_n, dram.dram_we_n} <= cmd_nxt;
            dram.dram_ba   <= ba_nxt;
            dram.dram_addr <= addr_nxt;
            init_done      <= (state_nxt == S_DONE);
            if (state_nxt == S_MRDLL && state != S_MRDLL) begin
                dll_run <= 1'b1;
                dll_cnt <= '0;
            end else if (dll_run && dll_cnt != DLL_MAX) begin
                dll_cnt <= dll_cnt + DLL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ddr2_init_sequencer.sv
// Directed bench for ddr2_init_sequencer. Two instances share clock/reset:
// dut_a (T_DLL=20, phy_rdy high from the start) and dut_b (T_DLL=100,
// phy_rdy held low until cycle 50). Cycle 0 is the cycle in which reset is
// released; every cycle is sampled one time unit after the falling edge.
module tb_ddr2_init_sequencer;

    localparam logic [3:0] DESEL = 4'b1111;
    localparam logic [3:0] NOP   = 4'b0111;
    localparam logic [3:0] PRE   = 4'b0010;
    localparam logic [3:0] REF   = 4'b0001;
    localparam logic [3:0] MRS   = 4'b0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic phy_rdy_a = 1'b1;
    logic phy_rdy_b = 1'b0;
    logic done_a, done_b;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ddr2_init_sequencer_if #(.ROW_WIDTH(14), .BANK_WIDTH(3)) bus_a ();
    ddr2_init_sequencer_if #(.ROW_WIDTH(14), .BANK_WIDTH(3)) bus_b ();

    ddr2_init_sequencer #(
        .ROW_WIDTH(14), .BANK_WIDTH(3), .T_PWRUP(10), .T_XPR(4), .T_RP(2),
        .T_MRD(2), .T_RFC(5), .T_DLL(20), .CAS_LAT(4), .BURST_LEN(4),
        .WR_REC(4), .ADD_LAT(0)
    ) dut_a (
        .dram_clk_div   (clk),
        .dram_rst_div_n (rst_n),
        .phy_rdy        (phy_rdy_a),
        .dram           (bus_a),
        .init_done      (done_a)
    );

    ddr2_init_sequencer #(
        .ROW_WIDTH(14), .BANK_WIDTH(3), .T_PWRUP(10), .T_XPR(4), .T_RP(2),
        .T_MRD(2), .T_RFC(5), .T_DLL(100), .CAS_LAT(4), .BURST_LEN(4),
        .WR_REC(4), .ADD_LAT(0)
    ) dut_b (
        .dram_clk_div   (clk),
        .dram_rst_div_n (rst_n),
        .phy_rdy        (phy_rdy_b),
        .dram           (bus_b),
        .init_done      (done_b)
    );

    wire [3:0] cmd_a = {bus_a.dram_cs_n, bus_a.dram_ras_n, bus_a.dram_cas_n, bus_a.dram_we_n};
    wire [3:0] cmd_b = {bus_b.dram_cs_n, bus_b.dram_ras_n, bus_b.dram_cas_n, bus_b.dram_we_n};

    // Command schedule with CKE rising in cycle 10 (hand-derived:
    // PRE at 10+tXPR, then each command W+1 cycles after the previous one).
    int         sch_cyc  [11] = '{14, 17, 20, 23, 26, 29, 32, 38, 44, 47, 50};
    logic [3:0] sch_cmd  [11] = '{PRE, MRS, MRS, MRS, MRS, PRE, REF, REF, MRS, MRS, MRS};
    logic [2:0] sch_ba   [11] = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
    logic [13:0] sch_addr[11] = '{14'h0400, 14'h0000, 14'h0000, 14'h0004, 14'h0742, 14'h0400,
                                  14'h0000, 14'h0000, 14'h0642, 14'h0384, 14'h0004};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_bus(input string nm, input int cyc, input int cke_cyc, input int done_cyc,
                             input logic cke, input logic [3:0] cmd, input logic [2:0] ba,
                             input logic [13:0] addr, input logic done);
        logic [3:0] e_cmd;
        int idx;
        idx   = -1;
        e_cmd = (cyc < cke_cyc) ? DESEL : NOP;
        for (int i = 0; i < 11; i++)
            if (cyc == sch_cyc[i] + cke_cyc - 10) idx = i;
        if (idx >= 0) e_cmd = sch_cmd[idx];
        chk($sformatf("%s_bus_c%0d", nm, cyc), {26'd0, cke, done, cmd},
            {26'd0, (cyc >= cke_cyc), (cyc >= done_cyc), e_cmd});
        if (idx >= 0 && e_cmd != REF)
            chk($sformatf("%s_ba_addr_c%0d", nm, cyc), {15'd0, ba, addr},
                {15'd0, sch_ba[idx], sch_addr[idx]});
    endtask

    initial begin
        // Reset hold while the clock runs.
        repeat (5) @(negedge clk);
        #1;
        chk("rst_hold_a", {28'd0, bus_a.dram_cke, bus_a.dram_cs_n, done_a, 1'b0}, 32'h4);
        chk("rst_hold_b", {28'd0, bus_b.dram_cke, bus_b.dram_cs_n, done_b, 1'b0}, 32'h4);
        chk("rst_cmd_addr_a", {15'd0, cmd_a, bus_a.dram_ba, bus_a.dram_addr}, {15'd0, DESEL, 17'd0});

        // Full sequences: dut_a done at 53 (DLL already satisfied),
        // dut_b CKE at 51, MRDLL at 67, done at 67+100.
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc <= 200; cyc++) begin
            if (cyc == 50) phy_rdy_b = 1'b1;
            #1;
            check_bus("a", cyc, 10, 53, bus_a.dram_cke, cmd_a, bus_a.dram_ba, bus_a.dram_addr, done_a);
            check_bus("b", cyc, 51, 167, bus_b.dram_cke, cmd_b, bus_b.dram_ba, bus_b.dram_addr, done_b);
            @(negedge clk);
        end

        // phy_rdy activity after init_done is ignored.
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (cyc % 7 == 0) begin
                phy_rdy_a = ~phy_rdy_a;
                phy_rdy_b = ~phy_rdy_b;
            end
            #1;
            chk($sformatf("post_a_c%0d", cyc), {25'd0, bus_a.dram_cke, done_a, cmd_a, 1'b0},
                {25'd0, 1'b1, 1'b1, NOP, 1'b0});
            chk($sformatf("post_b_c%0d", cyc), {25'd0, bus_b.dram_cke, done_b, cmd_b, 1'b0},
                {25'd0, 1'b1, 1'b1, NOP, 1'b0});
            @(negedge clk);
        end

        // Restart, then abort asynchronously in the REF1 wait (cycles 33-37).
        rst_n = 1'b0;
        phy_rdy_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc <= 34; cyc++) begin
            #1;
            if (cyc == 14)
                chk("restart_pre_a", {28'd0, cmd_a}, {28'd0, PRE});
            if (cyc == 34)
                chk("pre_abort_cke_a", {31'd0, bus_a.dram_cke}, 32'd1);
            if (cyc < 34) @(negedge clk);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ctl_a", {26'd0, bus_a.dram_cke, cmd_a, done_a}, {26'd0, 1'b0, DESEL, 1'b0});
        chk("abort_ba_addr_a", {15'd0, bus_a.dram_ba, bus_a.dram_addr}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
